// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the TDM multiplexer / scanner.
//   MODE_DIRECT / MODE_SCAN : encodings of the 'mode' input
//   state_t                 : scan FSM state encoding
package tdm_mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin next-set-bit finder (purely combinational).
// Returns the first set bit of 'mask' strictly above 'cur', wrapping from
// N-1 to 0. The search includes 'cur' itself as the last candidate, so a
// mask with a single bit always yields that bit. Passing cur = N-1 yields
// the lowest set bit.
//   mask : channel mask
//   cur  : current channel index
//   nxt  : next set channel index (0 when none)
//   none : mask is empty
module rr_next_sel #(
    parameter int N  = 16,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] cur,
    output logic [SW-1:0] nxt,
    output logic          none
);

    logic [SW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        idx  = '0;
        for (int off = N; off >= 1; off--) begin
            idx = SW'((int'(cur) + off) % N);
            if (mask[idx]) begin
                nxt  = idx;
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdm_mux_scan.sv
// N-channel registered multiplexer with valid/ready output.
// Direct mode captures in[sel] every cycle the output slot is free.
// Scan mode walks the enabled channels round-robin, waits 'dwell' cycles on
// each, then emits one sample tagged with its channel index.
//
// Handshake: y/y_ch are valid while y_valid=1 and are consumed on a cycle
// with y_valid && y_ready. The slot is free when !y_valid || y_ready, so a
// new capture may land in the same cycle as a consumption; y/y_ch never
// change while y_valid && !y_ready.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in           : packed channel data, channel k at in[k*W +: W]
//   sel          : direct-mode channel index
//   mode         : MODE_DIRECT / MODE_SCAN
//   ch_en        : scan channel mask
//   dwell        : wait cycles per channel in scan mode
//   start        : pulse to begin a scan
//   y, y_ch      : registered sample and its channel
//   y_valid      : sample pending
//   y_ready      : consumer accept
//   busy         : scan FSM not IDLE
//   dbg_state    : current scan FSM state
module tdm_mux_scan
    import tdm_mux_pkg::*;
#(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int SW = $clog2(N),
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic [N-1:0]   ch_en,
    input  logic [DW-1:0]  dwell,
    input  logic           start,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_ch,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           busy,
    output state_t         dbg_state
);

    state_t        state;
    logic [SW-1:0] ptr;
    logic [DW-1:0] cnt;

    logic          slot_free;
    logic [SW-1:0] rr_cur;
    logic [SW-1:0] rr_nxt;
    logic          rr_none;
    logic [SW-1:0] pick_idx;
    logic [W-1:0]  pick_data;

    assign slot_free = !y_valid || y_ready;
    assign dbg_state = state;

    // In IDLE the finder is asked for the lowest set bit (start load);
    // in scan states it supplies the channel after the current pointer.
    assign rr_cur   = (state == IDLE) ? SW'(N - 1) : ptr;
    assign pick_idx = (state == IDLE) ? sel : ptr;

    rr_next_sel #(
        .N  (N),
        .SW (SW)
    ) u_rr_next_sel (
        .mask (ch_en),
        .cur  (rr_cur),
        .nxt  (rr_nxt),
        .none (rr_none)
    );

    // Selector that yields 0 for indices beyond N-1 (non-power-of-2 N).
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < N; k++) begin
            if (pick_idx == SW'(k)) begin
                pick_data = in[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // Consumption; overridden below by a same-cycle capture.
            if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (mode == MODE_DIRECT) begin
                        if (slot_free) begin
                            y       <= pick_data;
                            y_ch    <= pick_idx;
                            y_valid <= 1'b1;
                        end
                    end else if (start && !rr_none) begin
                        state <= DWELL;
                        ptr   <= rr_nxt;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                DWELL, HOLD: begin
                    if (mode != MODE_SCAN) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (state == HOLD || cnt == dwell) begin
                        if (slot_free) begin
                            y       <= pick_data;
                            y_ch    <= pick_idx;
                            y_valid <= 1'b1;
                            cnt     <= '0;
                            // Mask is re-read here; an empty mask ends the scan.
                            if (rr_none) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DWELL;
                                ptr   <= rr_nxt;
                            end
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mux_scan.sv
module tb_tdm_mux_scan;
    import tdm_mux_pkg::*;

    localparam int N  = 16;
    localparam int W  = 8;
    localparam int SW = 4;
    localparam int DW = 8;
    localparam int EW = SW + W;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N*W-1:0] in_bus;
    logic [SW-1:0]  sel;
    logic           mode;
    logic [N-1:0]   ch_en;
    logic [DW-1:0]  dwell;
    logic           start;
    logic [W-1:0]   y;
    logic [SW-1:0]  y_ch;
    logic           y_valid;
    logic           y_ready;
    logic           busy;
    state_t         dbg_state;

    logic [W-1:0]   chan [N];

    always_comb begin
        in_bus = '0;
        for (int k = 0; k < N; k++) in_bus[k*W +: W] = chan[k];
    end

    tdm_mux_scan #(.N(N), .W(W), .SW(SW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_bus),
        .sel       (sel),
        .mode      (mode),
        .ch_en     (ch_en),
        .dwell     (dwell),
        .start     (start),
        .y         (y),
        .y_ch      (y_ch),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [EW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    bit m_valid;
    bit m_busy;
    bit m_hold;
    int m_ptr;
    int m_age;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_set(input logic [N-1:0] m, input int from);
        for (int off = 1; off <= N; off++) begin
            if (m[(from + off) % N]) return (from + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_busy  = 0;
        m_hold  = 0;
        m_ptr   = 0;
        m_age   = 0;
        exp_q.delete();
    endtask

    // Effect of one rising edge, using the inputs presented at that edge.
    task automatic model_edge();
        bit free;
        bit consume;
        bit cap;
        int cap_ch;
        int n;
        logic [W-1:0] cap_d;
        free    = !m_valid || y_ready;
        consume = m_valid && y_ready;
        cap     = 0;
        cap_ch  = 0;
        cap_d   = '0;
        if (!m_busy) begin
            if (!mode) begin
                if (free) begin
                    cap    = 1;
                    cap_ch = int'(sel);
                    cap_d  = (int'(sel) < N) ? chan[sel] : '0;
                end
            end else if (start && ch_en != '0) begin
                m_busy = 1;
                m_hold = 0;
                m_ptr  = next_set(ch_en, N - 1);
                m_age  = 0;
            end
        end else if (!mode) begin
            m_busy = 0;
            m_hold = 0;
        end else if (m_age >= int'(dwell)) begin
            if (free) begin
                cap    = 1;
                cap_ch = m_ptr;
                cap_d  = chan[m_ptr];
                m_hold = 0;
                m_age  = 0;
                n = next_set(ch_en, m_ptr);
                if (n < 0) m_busy = 0;
                else       m_ptr  = n;
            end else begin
                m_hold = 1;
            end
        end else begin
            m_age++;
        end
        if (cap) begin
            m_valid = 1;
            exp_q.push_back({SW'(cap_ch), cap_d});
        end else if (consume) begin
            m_valid = 0;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        logic [31:0]   exp_st;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_st = !m_busy ? 32'(IDLE) : (m_hold ? 32'(HOLD) : 32'(DWELL));
                chk("y_valid", 32'(y_valid), 32'(m_valid));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("state", 32'(dbg_state), exp_st);
                if (y_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_sample: got ch %0d data %0h expected none", y_ch, y);
                    end else begin
                        e = exp_q[0];
                        chk("y", 32'(y), 32'(e[W-1:0]));
                        chk("y_ch", 32'(y_ch), 32'(e[EW-1:W]));
                        if (y_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) model_edge();
    endtask

    task automatic load_ramp();
        for (int k = 0; k < N; k++) chan[k] = 8'h10 + 8'(k);
    endtask

    task automatic run_scan(input logic [N-1:0] mask, input logic [DW-1:0] dw, input int cycles);
        ch_en = mask;
        dwell = dw;
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (cycles) tick();
    endtask

    task automatic to_direct();
        mode    = 1'b0;
        y_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        sel     = '0;
        mode    = 1'b0;
        ch_en   = '0;
        dwell   = '0;
        start   = 1'b0;
        y_ready = 1'b0;
        load_ramp();
        model_reset();
        tick();
        tick();
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_y_ch", 32'(y_ch), 32'h0);
        chk("rst_y_valid", 32'(y_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Direct sweep, consumer always ready.
        y_ready = 1'b1;
        for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            tick();
        end

        // Direct with backpressure: sample frozen while stalled.
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = SW'(i + 3);
            tick();
        end
        y_ready = 1'b1;
        repeat (2) tick();

        // Random direct traffic.
        for (int i = 0; i < 40; i++) begin
            sel     = SW'($urandom_range(0, N - 1));
            y_ready = 1'($urandom_range(0, 1));
            chan[$urandom_range(0, N - 1)] = 8'($urandom_range(0, 255));
            tick();
        end
        load_ramp();
        to_direct();

        // Scan 0,5,10,15 with dwell 3; a start while busy is ignored.
        run_scan(16'h8421, 8'd3, 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        to_direct();

        // dwell 0, two channels, ready toggling.
        ch_en = 16'h0003;
        dwell = 8'd0;
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            y_ready = (i % 2 == 0);
            tick();
        end
        to_direct();

        // start with empty mask is ignored.
        run_scan(16'h0000, 8'd1, 4);
        to_direct();

        // Mask emptied mid-scan: one final capture then IDLE.
        run_scan(16'h0f0f, 8'd2, 10);
        ch_en = '0;
        repeat (10) tick();
        to_direct();

        // Randomised mixed traffic.
        for (int i = 0; i < 300; i++) begin
            y_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) chan[$urandom_range(0, N - 1)] = 8'($urandom_range(0, 255));
            sel   = SW'($urandom_range(0, N - 1));
            start = 1'b0;
            if (!m_busy) begin
                if ($urandom_range(0, 3) == 0) begin
                    dwell = DW'($urandom_range(0, 3));
                    ch_en = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(1, 65535));
                    mode  = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                end
            end else begin
                if ($urandom_range(0, 19) == 0)
                    ch_en = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(1, 65535));
                if ($urandom_range(0, 29) == 0) mode = 1'b0;
                start = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = 1'b0;
        to_direct();

        // Reset asserted while in HOLD with a pending sample.
        y_ready = 1'b0;
        run_scan(16'h0001, 8'd1, 4);
        chk("hold_before_reset", 32'(m_hold), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_y_valid", 32'(y_valid), 32'h0);
        chk("async_rst_y", 32'(y), 32'h0);
        chk("async_rst_y_ch", 32'(y_ch), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        model_reset();
        tick();
        rst_n   = 1'b1;
        mode    = 1'b0;
        y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel = SW'($urandom_range(0, N - 1));
            tick();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_mux_scan.md
Name: tdm_mux_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready output and two modes: direct select and autonomous round-robin scan.
- Scan mode walks the enabled channels, dwells a programmable number of cycles on each, and emits one tagged sample per channel.
- Sits between a bank of sensor/status sources and a single narrow consumer such as a serialiser or logger.
- Backpressure from the consumer stalls the block; no sample is ever dropped.

Parameters:
- N, 16, number of input channels (N >= 2)
- W, 8, data width per channel
- SW, $clog2(N), channel index width
- DW, 8, dwell counter width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  N*W  packed channel data; channel k is in[k*W +: W]
- sel  input  SW  channel index used in direct mode
- mode  input  1  0 = direct, 1 = scan
- ch_en  input  N  per-channel enable mask, scan mode only
- dwell  input  DW  cycles to wait on each channel before sampling, scan mode
- start  input  1  single-cycle pulse that begins a scan
- y  output  W  registered sample
- y_ch  output  SW  channel index of the sample in y
- y_valid  output  1  y and y_ch hold an unconsumed sample
- y_ready  input  1  consumer accepts the sample when y_valid && y_ready
- busy  output  1  scan FSM is not IDLE

Behaviour:
- Reset (async assert, sync release):
  - y=0, y_ch=0, y_valid=0, busy=0
  - state=IDLE, scan pointer=0, dwell counter=0
- Output slot is free when !y_valid || y_ready. A capture may occur in the same cycle as a consumption, giving 1 sample/cycle throughput.
- A capture loads y, y_ch and sets y_valid=1. y_valid clears only on a handshake with no simultaneous capture.
- y and y_ch stay stable while y_valid && !y_ready.
- Direct mode (mode=0, state IDLE):
  - Every cycle with a free slot, capture in[sel] with y_ch=sel. Latency from sel/in to y is 1 cycle.
  - sel >= N (non-power-of-2 N): capture y=0 with y_ch=sel.
- Scan FSM states: IDLE, DWELL, HOLD.
  - IDLE -> DWELL on start && mode && ch_en!=0. Pointer loads the lowest set bit of ch_en; counter=0.
  - start with ch_en==0, or with mode=0: ignored, remain IDLE.
  - start while busy: ignored.
  - DWELL: counter increments each cycle. When counter==dwell, sample the pointed channel:
    - Slot free: capture, advance the pointer to the next set bit of ch_en above the current one (wrapping from N-1 to 0), reset the counter, remain in DWELL.
    - Slot not free: go to HOLD with the counter frozen.
  - HOLD: capture on the first cycle the slot is free, advance the pointer, return to DWELL.
  - dwell=0: sample every cycle, so with y_ready held high there is one sample per cycle.
  - ch_en read at each advance. If the mask becomes 0, go to IDLE after the current capture.
  - A single enabled channel is resampled repeatedly.
  - mode=0 in DWELL or HOLD: go to IDLE next cycle with no capture. A pending y_valid remains until consumed.
  - Scan runs until mode drops or the mask empties; there is no auto-stop.
  - In scan states, direct-mode capture is disabled.
- busy=1 in DWELL and HOLD.
- Reset mid-scan: immediate return to reset values; the pending sample is lost.

Decomposition:
- Package tdm_mux_pkg:
  - mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1
  - state enum {IDLE, DWELL, HOLD}
- Sub-module rr_next_sel (purely combinational, parameter N). Takes the mask and current index; returns the next set index above current with wrap, plus a none flag. Reused for the lowest-set-bit load by passing index N-1.

Test Plan:
- Direct mode, N=16, W=8, in[k]=8'h10+k, y_ready=1, sel sweeps 0..15 one per cycle -> each cycle after the first: y=8'h10+sel(prev), y_ch=sel(prev), y_valid=1.
- Direct mode, y_ready=0 for 5 cycles while sel changes -> y and y_ch frozen at the first captured value. Release y_ready -> new sample the next cycle.
- Scan, ch_en=16'h8421, dwell=3, y_ready=1, start pulse -> samples on channels 0,5,10,15,0,... spaced 4 cycles apart, busy=1 throughout.
- Scan, dwell=0, ch_en=16'h0003, y_ready toggled 1/0 -> channel order 0,1,0,1 with no skips. FSM in HOLD whenever ready=0 and the slot is full.
- start with ch_en=0 -> busy stays 0 and no y_valid. Mid-scan ch_en->0 -> one final capture, then IDLE.
- rst_n asserted mid-HOLD with y_valid=1 -> y_valid=0, y=0, busy=0 asynchronously. After release, direct mode resumes.
